// File: rtl/arith_pkg.sv
// Shared definitions for the sequential shift-add multiplier and shift-subtract divider.
// Holds the default operand width and the common start/iterate/complete state encoding.
package arith_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift ACC left and try to subtract the divisor.
// Combinational, zero latency; no flow control.
module div_step #(
    parameter int N = 8
) (
    input  logic [2*N-1:0] i_acc,
    input  logic [N-1:0]   i_dreg,
    output logic [2*N:0]   o_acc
);

    logic [2*N:0] w_s;
    logic [N:0]   w_t;
    logic         w_ge;

    // ACC's top bit is always zero between iterations, so it is simply shifted out.
    assign w_s   = {i_acc, 1'b0};
    assign w_ge  = w_s[2*N:N] >= {1'b0, i_dreg};
    assign w_t   = w_s[2*N:N] - {1'b0, i_dreg};
    assign o_acc = w_ge ? {w_t, w_s[N-1:1], 1'b1} : w_s;

endmodule

// File: rtl/seq_divider_shift_sub.sv
// Sequential restoring divider, 2N-bit dividend by N-bit divisor, St/Done handshake.
// Latency N+1 cycles from the accepting edge (1 cycle on overflow/divide-by-zero); St ignored while Busy.
module seq_divider_shift_sub
    import arith_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           St,
    input  logic [2*N-1:0] Dividend,
    input  logic [N-1:0]   Divisor,
    output logic           Busy,
    output logic           Done,
    output logic           V,
    output logic [N-1:0]   Quotient,
    output logic [N-1:0]   Remainder
);

    localparam int CW = $clog2(N + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2*N:0]   r_acc;
    logic [N-1:0]   r_dreg;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_quot;
    logic [N-1:0]   r_rem;
    logic           r_v;
    logic [2*N:0]   w_acc_nxt;
    logic           w_ovf;
    logic           w_last;

    // A quotient wider than N bits exists exactly when the upper dividend half reaches the divisor.
    assign w_ovf  = (r_dreg == '0) || (r_acc[2*N:N] >= {1'b0, r_dreg});
    assign w_last = (r_cnt == CW'(N - 1));

    div_step #(.N(N)) u_div_step (
        .i_acc  (r_acc[2*N-1:0]),
        .i_dreg (r_dreg),
        .o_acc  (w_acc_nxt)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (St) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = w_ovf ? S_DONE : S_ITER;
            S_ITER:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Results are loaded on the edge that enters DONE so they are valid together with Done.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_acc  <= '0;
            r_dreg <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_v    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (St) begin
                        r_acc  <= {1'b0, Dividend};
                        r_dreg <= Divisor;
                    end
                end
                S_CHECK: begin
                    r_cnt <= '0;
                    if (w_ovf) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_v    <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot <= w_acc_nxt[N-1:0];
                        r_rem  <= w_acc_nxt[2*N-1:N];
                        r_v    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (r_state != S_IDLE);
    assign Done      = (r_state == S_DONE);
    assign V         = r_v;
    assign Quotient  = r_quot;
    assign Remainder = r_rem;

endmodule
